// File: rtl/hazard_ctrl.sv
// Hazard and pipeline-steering controller: load-use stalls, branch/JAL squash
// sequencing and saturating event counters for the 5-stage core.
`ifndef ASIZE
`define ASIZE 5
`endif

module hazard_ctrl #(
   parameter int FLUSH_CYCLES = 2,
   parameter bit R0_HARDWIRED = 1'b1,
   parameter int CNT_W        = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [`ASIZE-1:0]  id_raddr1,
   input  logic [`ASIZE-1:0]  id_raddr2,
   input  logic               id_uses_rs2,
   input  logic               idex_memRead,
   input  logic               idex_wen,
   input  logic [`ASIZE-1:0]  idex_waddr,
   input  logic               idex_branch,
   input  logic               idex_jal,
   input  logic               exe_branch_taken,
   output logic               pc_stall,
   output logic               ifid_stall,
   output logic               ifid_flush,
   output logic               idex_bubble,
   output logic               busy,
   output logic [CNT_W-1:0]   stall_count,
   output logic [CNT_W-1:0]   flush_count
);

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_t;

   localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [2:0]        r_flush_left;
   logic [2:0]        w_flush_left_nxt;
   logic [CNT_W-1:0]  r_stall_count;
   logic [CNT_W-1:0]  r_flush_count;

   logic w_redirect;
   logic w_load_use;
   logic w_waddr_live;
   logic w_stall_inc;
   logic w_flush_inc;

   assign w_redirect   = (idex_branch & exe_branch_taken) | idex_jal;
   assign w_waddr_live = (idex_waddr != '0) || !R0_HARDWIRED;
   assign w_load_use   = idex_memRead & idex_wen & w_waddr_live &
                         ((idex_waddr == id_raddr1) |
                          (id_uses_rs2 & (idex_waddr == id_raddr2)));

   // NOTE: every signal gets a default before the case so no latch is inferred.
   always_comb begin
      w_state_nxt      = r_state;
      w_flush_left_nxt = r_flush_left;
      pc_stall         = 1'b0;
      ifid_stall       = 1'b0;
      ifid_flush       = 1'b0;
      idex_bubble      = 1'b0;
      w_stall_inc      = 1'b0;
      w_flush_inc      = 1'b0;

      if (!rst) begin
         case (r_state)
            RUN: begin
               // Redirect wins: the ID instruction behind it is squashed anyway.
               if (w_redirect) begin
                  ifid_flush  = 1'b1;
                  idex_bubble = 1'b1;
                  w_flush_inc = 1'b1;
                  if (FLUSH_CYCLES > 1) begin
                     w_state_nxt      = FLUSH;
                     w_flush_left_nxt = FLUSH_INIT;
                  end
               end else if (w_load_use) begin
                  pc_stall    = 1'b1;
                  ifid_stall  = 1'b1;
                  idex_bubble = 1'b1;
                  w_stall_inc = 1'b1;
               end
            end
            FLUSH: begin
               ifid_flush  = 1'b1;
               idex_bubble = 1'b1;
               if (r_flush_left <= 3'd1) begin
                  w_state_nxt      = RUN;
                  w_flush_left_nxt = 3'd0;
               end else begin
                  w_flush_left_nxt = r_flush_left - 3'd1;
               end
            end
            default: w_state_nxt = RUN;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= RUN;
         r_flush_left <= 3'd0;
      end else begin
         r_state      <= w_state_nxt;
         r_flush_left <= w_flush_left_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_count <= '0;
         r_flush_count <= '0;
      end else begin
         if (w_stall_inc && !(&r_stall_count)) r_stall_count <= r_stall_count + 1'b1;
         if (w_flush_inc && !(&r_flush_count)) r_flush_count <= r_flush_count + 1'b1;
      end
   end

   assign busy        = !rst && (r_state == FLUSH);
   assign stall_count = rst ? '0 : r_stall_count;
   assign flush_count = rst ? '0 : r_flush_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl; two instances with different
// parameters are checked against a cycle-level behavioural model.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] id_raddr1, id_raddr2, idex_waddr;
   logic       id_uses_rs2, idex_memRead, idex_wen;
   logic       idex_branch, idex_jal, exe_branch_taken;

   logic        pc_stall0, ifid_stall0, ifid_flush0, idex_bubble0, busy0;
   logic [15:0] stall_count0, flush_count0;
   logic        pc_stall1, ifid_stall1, ifid_flush1, idex_bubble1, busy1;
   logic [2:0]  stall_count1, flush_count1;

   int total = 0;
   int bad   = 0;

   // Reference model state: remaining squash cycles and event counts.
   int fcy  [2] = '{2, 1};
   bit r0hw [2] = '{1'b1, 1'b0};
   int maxc [2] = '{65535, 7};
   int rem  [2] = '{0, 0};
   int sc   [2] = '{0, 0};
   int fc   [2] = '{0, 0};

   always #5 clk = ~clk;

   hazard_ctrl #(.FLUSH_CYCLES(2), .R0_HARDWIRED(1'b1), .CNT_W(16)) dut0 (
      .clk(clk), .rst(rst),
      .id_raddr1(id_raddr1), .id_raddr2(id_raddr2), .id_uses_rs2(id_uses_rs2),
      .idex_memRead(idex_memRead), .idex_wen(idex_wen), .idex_waddr(idex_waddr),
      .idex_branch(idex_branch), .idex_jal(idex_jal), .exe_branch_taken(exe_branch_taken),
      .pc_stall(pc_stall0), .ifid_stall(ifid_stall0), .ifid_flush(ifid_flush0),
      .idex_bubble(idex_bubble0), .busy(busy0),
      .stall_count(stall_count0), .flush_count(flush_count0)
   );

   hazard_ctrl #(.FLUSH_CYCLES(1), .R0_HARDWIRED(1'b0), .CNT_W(3)) dut1 (
      .clk(clk), .rst(rst),
      .id_raddr1(id_raddr1), .id_raddr2(id_raddr2), .id_uses_rs2(id_uses_rs2),
      .idex_memRead(idex_memRead), .idex_wen(idex_wen), .idex_waddr(idex_waddr),
      .idex_branch(idex_branch), .idex_jal(idex_jal), .exe_branch_taken(exe_branch_taken),
      .pc_stall(pc_stall1), .ifid_stall(ifid_stall1), .ifid_flush(ifid_flush1),
      .idex_bubble(idex_bubble1), .busy(busy1),
      .stall_count(stall_count1), .flush_count(flush_count1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit redirect_now();
      return (idex_branch & exe_branch_taken) | idex_jal;
   endfunction

   function automatic bit load_use_now(input int k);
      bit dep;
      dep = (idex_waddr == id_raddr1) || (id_uses_rs2 && (idex_waddr == id_raddr2));
      return idex_memRead && idex_wen && ((idex_waddr != 5'd0) || !r0hw[k]) && dep;
   endfunction

   // Expected {pc_stall, ifid_stall, ifid_flush, idex_bubble, busy}.
   function automatic logic [4:0] model_flags(input int k);
      if (rst)                 return 5'b00000;
      else if (rem[k] > 0)     return 5'b00111;
      else if (redirect_now()) return 5'b00110;
      else if (load_use_now(k)) return 5'b11010;
      else                     return 5'b00000;
   endfunction

   function automatic void model_step(input int k);
      if (rst) begin
         rem[k] = 0; sc[k] = 0; fc[k] = 0;
      end else if (rem[k] > 0) begin
         rem[k]--;
      end else if (redirect_now()) begin
         if (fc[k] < maxc[k]) fc[k]++;
         rem[k] = fcy[k] - 1;
      end else if (load_use_now(k)) begin
         if (sc[k] < maxc[k]) sc[k]++;
      end
   endfunction

   task automatic cyc(input string tag);
      logic [4:0] got0, got1;
      @(negedge clk);
      got0 = {pc_stall0, ifid_stall0, ifid_flush0, idex_bubble0, busy0};
      got1 = {pc_stall1, ifid_stall1, ifid_flush1, idex_bubble1, busy1};
      check({tag, ".flags0"}, 32'(got0), 32'(model_flags(0)));
      check({tag, ".stall_cnt0"}, 32'(stall_count0), rst ? 32'd0 : 32'(sc[0]));
      check({tag, ".flush_cnt0"}, 32'(flush_count0), rst ? 32'd0 : 32'(fc[0]));
      check({tag, ".flags1"}, 32'(got1), 32'(model_flags(1)));
      check({tag, ".stall_cnt1"}, 32'(stall_count1), rst ? 32'd0 : 32'(sc[1]));
      check({tag, ".flush_cnt1"}, 32'(flush_count1), rst ? 32'd0 : 32'(fc[1]));
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
   endtask

   task automatic idle();
      id_raddr1 = 5'd0; id_raddr2 = 5'd0; id_uses_rs2 = 1'b0;
      idex_memRead = 1'b0; idex_wen = 1'b0; idex_waddr = 5'd0;
      idex_branch = 1'b0; idex_jal = 1'b0; exe_branch_taken = 1'b0;
   endtask

   task automatic rand_inputs(input int amax);
      id_raddr1        = 5'($urandom_range(0, amax));
      id_raddr2        = 5'($urandom_range(0, amax));
      idex_waddr       = 5'($urandom_range(0, amax));
      id_uses_rs2      = 1'($urandom);
      idex_memRead     = ($urandom_range(0, 2) != 0);
      idex_wen         = ($urandom_range(0, 3) != 0);
      idex_branch      = ($urandom_range(0, 4) == 0);
      exe_branch_taken = 1'($urandom);
      idex_jal         = ($urandom_range(0, 9) == 0);
   endtask

   initial begin
      idle();
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         rand_inputs(31);
         cyc("reset_hold");
      end
      rst = 1'b0;
      idle();
      cyc("after_reset");

      // Load-use on rs1, then the nonzero/zero destination and unused-rs2 cases.
      idex_memRead = 1'b1; idex_wen = 1'b1; idex_waddr = 5'd5; id_raddr1 = 5'd5;
      cyc("lu_rs1");
      idle();
      cyc("lu_rs1_after");
      idex_memRead = 1'b1; idex_wen = 1'b1; idex_waddr = 5'd0; id_raddr1 = 5'd0;
      cyc("lu_r0");
      idle();
      idex_memRead = 1'b1; idex_wen = 1'b1; idex_waddr = 5'd5;
      id_raddr1 = 5'd3; id_raddr2 = 5'd5; id_uses_rs2 = 1'b0;
      cyc("lu_rs2_unused");
      id_uses_rs2 = 1'b1;
      cyc("lu_rs2_used");
      idle();
      cyc("idle0");

      // Taken branch, not-taken branch.
      idex_branch = 1'b1; exe_branch_taken = 1'b1;
      cyc("br_taken");
      idle();
      for (int i = 0; i < 3; i++) cyc("br_taken_tail");
      idex_branch = 1'b1; exe_branch_taken = 1'b0;
      cyc("br_not_taken");
      idle();
      cyc("idle1");

      // Redirect with simultaneous load-use.
      idex_jal = 1'b1; idex_memRead = 1'b1; idex_wen = 1'b1;
      idex_waddr = 5'd7; id_raddr1 = 5'd7;
      cyc("prio");
      idle();
      for (int i = 0; i < 2; i++) cyc("prio_tail");

      // JAL held through the squash window.
      idex_jal = 1'b1;
      for (int i = 0; i < 2; i++) cyc("jal_held");
      idle();
      for (int i = 0; i < 2; i++) cyc("jal_held_tail");

      // Back-to-back load-use drives the narrow counter into saturation.
      idex_memRead = 1'b1; idex_wen = 1'b1; idex_waddr = 5'd9; id_raddr1 = 5'd9;
      for (int i = 0; i < 10; i++) cyc("sat");
      idle();
      cyc("sat_after");
      check("sat_value1", 32'(stall_count1), 32'd7);

      // Reset during the first FLUSH cycle aborts the squash.
      idex_branch = 1'b1; exe_branch_taken = 1'b1;
      cyc("abort_redirect");
      idle();
      rst = 1'b1;
      cyc("abort_rst");
      rst = 1'b0;
      cyc("abort_after");

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 600; i++) begin
         rand_inputs(3);
         rst = ($urandom_range(0, 99) == 0);
         cyc("rand");
      end
      rst = 1'b0;
      idle();
      cyc("final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Hazard and pipeline-steering controller for the 5-stage core. It reads the registered outputs of the ID/EX pipeline register together with the source-register fields of the instruction currently in decode. From these it generates the stall, bubble and flush controls that feed back into PC, IF/ID and ID/EX. It handles load-use stalls and branch/JAL squashing, and keeps saturating event counters for performance debug.

## Interface
Parameters:
- FLUSH_CYCLES, 2: number of consecutive cycles the IF/ID flush is held after a taken branch or JAL resolves in EXE; legal range 1..7.
- R0_HARDWIRED, 1: when 1, a destination address of 0 never creates a hazard.
- CNT_W, 16: width of the event counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- id_raddr1  in  `ASIZE  rs1 address of the instruction in ID.
- id_raddr2  in  `ASIZE  rs2 address of the instruction in ID.
- id_uses_rs2  in  1  ID instruction reads rs2 (R-type, store, branch).
- idex_memRead  in  1  ID/EX memRead_out.
- idex_wen  in  1  ID/EX wen_out.
- idex_waddr  in  `ASIZE  ID/EX waddr_out.
- idex_branch  in  1  ID/EX branch_out.
- idex_jal  in  1  ID/EX jal_out.
- exe_branch_taken  in  1  EXE comparison result; qualified by idex_branch.
- pc_stall  out  1  hold PC.
- ifid_stall  out  1  hold IF/ID.
- ifid_flush  out  1  zero IF/ID contents.
- idex_bubble  out  1  load zeros into ID/EX (same effect as its rst).
- busy  out  1  state is not RUN.
- stall_count  out  CNT_W  load-use stall cycles, saturating.
- flush_count  out  CNT_W  redirect events (not cycles), saturating.

## Operation
- States: RUN, FLUSH. A down-counter flush_left (3 bits) is used in FLUSH.
- redirect = (idex_branch & exe_branch_taken) | idex_jal.
- load_use = idex_memRead & idex_wen & (idex_waddr != 0 | !R0_HARDWIRED) & ((idex_waddr == id_raddr1) | (id_uses_rs2 & idex_waddr == id_raddr2)).
- RUN, redirect:
  - assert ifid_flush and idex_bubble in the same cycle; pc_stall = 0.
  - flush_count += 1.
  - If FLUSH_CYCLES > 1: go to FLUSH with flush_left = FLUSH_CYCLES-1. Otherwise stay in RUN.
- RUN, load_use and no redirect:
  - assert pc_stall, ifid_stall and idex_bubble for this cycle only.
  - stall_count += 1.
  - Stay in RUN. The bubble clears idex_memRead, so the stall self-terminates after 1 cycle.
- Redirect has priority over load_use. A simultaneous load_use is dropped, because the ID instruction is being squashed.
- FLUSH:
  - assert ifid_flush and idex_bubble every cycle.
  - ignore redirect and load_use, since the inputs come from squashed instructions.
  - decrement flush_left; return to RUN when flush_left reaches 1.
- ifid_stall and ifid_flush are never asserted together.
- Counters saturate at all-ones and do not wrap.
- Stall and flush outputs are combinational from inputs and state, so they act in the same cycle. busy is state-only.

## Timing
- Reset: state = RUN, flush_left = 0, stall_count = 0, flush_count = 0.
- While rst is high, every output is 0; inputs are ignored during that cycle.
- rst asserted mid-FLUSH aborts the sequence. In the next cycle the block is in RUN with no flush asserted.
- Load-use penalty is exactly 1 cycle. Back-to-back dependent loads give 1 stall per dependent pair.
- Redirect penalty is FLUSH_CYCLES cycles of ifid_flush, beginning in the resolve cycle.
- Counter values update on the edge after the causing cycle.

## Test plan
- Reset: hold rst 2 cycles with random inputs -> all outputs 0 and counters 0 on the first cycle after release.
- Load-use: idex_memRead=1, idex_wen=1, idex_waddr=5, id_raddr1=5 -> pc_stall, ifid_stall and idex_bubble high for 1 cycle; stall_count=1. Repeat with waddr=0 -> no stall. Repeat with raddr2=5 and id_uses_rs2=0 -> no stall.
- Taken branch, FLUSH_CYCLES=2: idex_branch=1, exe_branch_taken=1 for 1 cycle -> ifid_flush high for exactly 2 cycles; busy high for 1 cycle; flush_count=1. Not-taken branch -> no flush.
- Priority: redirect and load_use in the same cycle -> flush only, pc_stall=0, stall_count unchanged.
- Redirect input held high during FLUSH -> no retrigger; flush_count increments once.
- Saturation and abort:
  - preload stall_count to 0xFFFE, then apply 3 load-use cycles -> stall_count stops at 0xFFFF.
  - assert rst in FLUSH cycle 1 -> in the next cycle busy=0 and ifid_flush=0.
